// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - architectural flag register plus a registered branch-condition resolver
module flag_cond_unit #(
    parameter logic [4:0] RESET_FLAGS = 5'b00000,
    parameter bit         BYPASS      = 1'b1,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flag_we_i,
    input  logic [4:0]       flags_i,
    input  logic             flush_i,
    input  logic             cond_valid_i,
    input  logic [3:0]       cond_i,
    output logic             cond_ready_o,
    output logic             taken_valid_o,
    output logic             taken_o,
    input  logic             taken_ready_i,
    output logic [4:0]       flags_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_CS = 4'h2;
    localparam logic [3:0] C_CC = 4'h3;
    localparam logic [3:0] C_HI = 4'h4;
    localparam logic [3:0] C_LS = 4'h5;
    localparam logic [3:0] C_GT = 4'h6;
    localparam logic [3:0] C_LE = 4'h7;
    localparam logic [3:0] C_FS = 4'h8;
    localparam logic [3:0] C_FC = 4'h9;
    localparam logic [3:0] C_LO = 4'hA;
    localparam logic [3:0] C_HS = 4'hB;
    localparam logic [3:0] C_LT = 4'hC;
    localparam logic [3:0] C_GE = 4'hD;
    localparam logic [3:0] C_UC = 4'hE;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [4:0]       flag_q;
    logic             taken_q;
    logic             taken_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       eval_flags;
    logic             accept;
    logic             pop;
    logic             result;
    logic             flag_f;
    logic             flag_l;
    logic             flag_c;
    logic             flag_n;
    logic             flag_z;

    // Same-cycle flag writes can be forwarded so a branch right after a compare sees it
    assign eval_flags = (BYPASS && flag_we_i) ? flags_i : flag_q;

    assign flag_f = eval_flags[4];
    assign flag_l = eval_flags[3];
    assign flag_c = eval_flags[2];
    assign flag_n = eval_flags[1];
    assign flag_z = eval_flags[0];

    always_comb begin
        result = 1'b0;
        unique case (cond_i)
            C_EQ:    result = flag_z;
            C_NE:    result = !flag_z;
            C_CS:    result = flag_c;
            C_CC:    result = !flag_c;
            C_HI:    result = flag_l;
            C_LS:    result = !flag_l;
            C_GT:    result = flag_n;
            C_LE:    result = !flag_n;
            C_FS:    result = flag_f;
            C_FC:    result = !flag_f;
            C_LO:    result = !flag_l && !flag_z;
            C_HS:    result = flag_l || flag_z;
            C_LT:    result = !flag_n && !flag_z;
            C_GE:    result = flag_n || flag_z;
            C_UC:    result = 1'b1;
            default: result = 1'b0;
        endcase
    end

    // Ready passes through from the consumer so a full buffer still sustains one result per cycle
    assign cond_ready_o = !flush_i && ((state_q == ST_EMPTY) || taken_ready_i);
    assign accept       = cond_valid_i && cond_ready_o;
    assign pop          = (state_q == ST_FULL) && taken_ready_i;

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
            taken_d = result;
        end else if (pop) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q <= RESET_FLAGS;
        end else if (flag_we_i) begin
            flag_q <= flags_i;
        end
    end

    // Flush outranks the pop, so a flushed result is never counted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (pop && taken_q && !flush_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign taken_valid_o = (state_q == ST_FULL);
    assign taken_o       = taken_q;
    assign flags_o       = flag_q;
    assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - directed and random checks of flag_cond_unit against a behavioural model
module tb_flag_cond_unit;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [4:0] flags_in;
    logic       flush;
    logic       valid;
    logic [3:0] cond;
    logic       tready;

    logic       rdy [2];
    logic       vld [2];
    logic       tk  [2];
    logic [4:0] fl  [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    int passes;
    int checks;

    logic [4:0]  m_flags [2];
    bit          m_full  [2];
    bit          m_res   [2];
    int unsigned m_cnt   [2];

    // dut 0: bypass on, 4-bit counter; dut 1: bypass off, default counter
    flag_cond_unit #(.RESET_FLAGS(5'b00000), .BYPASS(1'b1), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flag_we_i(we), .flags_i(flags_in), .flush_i(flush),
        .cond_valid_i(valid), .cond_i(cond), .cond_ready_o(rdy[0]), .taken_valid_o(vld[0]),
        .taken_o(tk[0]), .taken_ready_i(tready), .flags_o(fl[0]), .taken_cnt_o(cnt_a)
    );

    flag_cond_unit #(.RESET_FLAGS(5'b00000), .BYPASS(1'b0), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flag_we_i(we), .flags_i(flags_in), .flush_i(flush),
        .cond_valid_i(valid), .cond_i(cond), .cond_ready_o(rdy[1]), .taken_valid_o(vld[1]),
        .taken_o(tk[1]), .taken_ready_i(tready), .flags_o(fl[1]), .taken_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit eval(input logic [3:0] c, input logic [4:0] f);
        bit ff, l, cy, n, z;
        {ff, l, cy, n, z} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] obs_cnt(input int d);
        return (d == 0) ? {28'd0, cnt_a} : {16'd0, cnt_b};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_flags[d] = 5'b00000;
            m_full[d]  = 1'b0;
            m_res[d]   = 1'b0;
            m_cnt[d]   = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, d == 0 ? "_valid_a" : "_valid_b"}, {31'd0, vld[d]}, {31'd0, m_full[d]});
            if (m_full[d])
                check({tag, d == 0 ? "_taken_a" : "_taken_b"}, {31'd0, tk[d]}, {31'd0, m_res[d]});
            check({tag, d == 0 ? "_flags_a" : "_flags_b"}, {27'd0, fl[d]}, {27'd0, m_flags[d]});
            check({tag, d == 0 ? "_cnt_a" : "_cnt_b"}, obs_cnt(d), m_cnt[d]);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input bit r,
                         input bit w, input logic [4:0] f, input bit fl_in);
        valid = v; cond = c; tready = r; we = w; flags_in = f; flush = fl_in;
    endtask

    task automatic step(input string tag);
        logic [4:0] e;
        bit acc;
        #1;
        for (int d = 0; d < 2; d++) begin
            check({tag, d == 0 ? "_ready_a" : "_ready_b"}, {31'd0, rdy[d]},
                  {31'd0, !flush && (!m_full[d] || tready)});
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            e   = (d == 0 && we) ? flags_in : m_flags[d];
            acc = valid && !flush && (!m_full[d] || tready);
            if (flush) begin
                m_full[d] = 1'b0;
            end else begin
                if (m_full[d] && tready) begin
                    if (m_res[d]) m_cnt[d] = (m_cnt[d] + 1) % ((d == 0) ? 16 : 65536);
                    m_full[d] = 1'b0;
                end
                if (acc) begin
                    m_full[d] = 1'b1;
                    m_res[d]  = eval(cond, e);
                end
            end
            if (we) m_flags[d] = flags_in;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check({tag, "_rst_valid"}, {31'd0, vld[d]}, 32'd0);
            check({tag, "_rst_taken"}, {31'd0, tk[d]}, 32'd0);
            check({tag, "_rst_flags"}, {27'd0, fl[d]}, 32'd0);
            check({tag, "_rst_cnt"}, obs_cnt(d), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        passes = 0;
        checks = 0;
        rst_n  = 1'b1;
        model_reset();

        // reset while the ALU drives all ones
        drive(0, 4'h0, 0, 0, 5'b11111, 0);
        #3;
        async_reset("t1");
        drive(1, 4'hE, 0, 0, 5'b11111, 0);
        step("t1_uc");
        check("t1_uc_taken", {31'd0, tk[0]}, 32'd1);

        // forwarded flag write vs registered flags
        drive(1, 4'h0, 1, 1, 5'b00001, 0);
        step("t2_eq");
        check("t2_bypass_taken", {31'd0, tk[0]}, 32'd1);
        check("t2_nobypass_taken", {31'd0, tk[1]}, 32'd0);
        check("t2_nobypass_flags", {27'd0, fl[1]}, 32'd1);

        // back-to-back EQ/NE with Z set
        for (int i = 0; i < 8; i++) begin
            drive(1, (i % 2 == 0) ? 4'h0 : 4'h1, 1, 0, 5'b00000, 0);
            step("t3_b2b");
            check("t3_seq", {31'd0, tk[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // stall for three cycles, then release
        drive(1, 4'h1, 0, 0, 5'b00000, 0);
        for (int i = 0; i < 3; i++) step("t4_stall");
        drive(1, 4'h0, 1, 0, 5'b00000, 0);
        step("t4_release");

        // flush while full with consumer ready
        drive(1, 4'hE, 1, 0, 5'b00000, 1);
        step("t5_flush");
        drive(0, 4'hE, 1, 0, 5'b00000, 0);
        step("t5_after");

        // 17 taken pops wrap the 4-bit counter to 1
        async_reset("t6a");
        for (int i = 0; i < 18; i++) begin
            drive(1, 4'hE, 1, 0, 5'b00000, 0);
            step("t6_wrap");
        end
        check("t6_cnt_wrap", {28'd0, cnt_a}, 32'd1);
        drive(1, 4'hE, 1, 1, 5'b10101, 0);
        step("t6_mid");
        async_reset("t6b");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, 5'($urandom), $urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
